guess_entry: RTL and testbench

- Input-side producer for the game FSM: turns the raw `ready` push-button and the `userGuess` / `gameMode` switches into one clean, range-checked guess transaction per press.
- Synchronizes and debounces the button, detects a press and snapshots the switches.
- Rejects guesses outside the current mode's range.
- Holds a valid/ack handshake toward the FSM until the guess is consumed.

---
 rtl/guess_entry_if.sv | 33 +++
 rtl/guess_entry.sv | 155 +++++++++++++++
 tb/tb_guess_entry.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_entry_if.sv
// ---------------------------------------------------------------------------
// guess_entry_if
// Guess transaction bundle between the guess_entry producer and the game FSM.
//   guess_out    [3:0] captured guess, stable while guess_valid is high
//   guess_mode   [1:0] game mode captured together with the guess
//   guess_valid        guess presented, held until acknowledged
//   guess_reject       one-cycle pulse for an out-of-range press
//   guess_ack          consumer accepted the presented guess
// Modports: master = producer (guess_entry), slave = consumer (game FSM).
// ---------------------------------------------------------------------------
interface guess_entry_if;
  logic [3:0] guess_out;
  logic [1:0] guess_mode;
  logic       guess_valid;
  logic       guess_reject;
  logic       guess_ack;

  modport master (
    output guess_out,
    output guess_mode,
    output guess_valid,
    output guess_reject,
    input  guess_ack
  );

  modport slave (
    input  guess_out,
    input  guess_mode,
    input  guess_valid,
    input  guess_reject,
    output guess_ack
  );
endinterface

// File: rtl/guess_entry.sv
// ---------------------------------------------------------------------------
// guess_entry
// Turns the raw submit push-button and the guess/mode switches into one
// clean, range-checked guess transaction per press.
// Ports:
//   clock      system clock (single domain)
//   reset      synchronous, active-high reset
//   ready      raw asynchronous push-button
//   userGuess  raw guess switches [3:0]
//   gameMode   raw mode switches [1:0]
//   busy       high in every state except IDLE
//   gif        guess transaction (guess_out/guess_mode/guess_valid/
//              guess_reject out, guess_ack in)
// ---------------------------------------------------------------------------
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic [3:0]        userGuess,
  input  logic [1:0]        gameMode,
  output logic              busy,
  guess_entry_if.master     gif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_RELEASE = 2'd0,
    S_IDLE         = 2'd1,
    S_HOLD         = 2'd2
  } state_t;

  logic [1:0]       r_rdy_sync;
  logic [3:0]       r_guess_s1, r_guess_s2;
  logic [1:0]       r_mode_s1, r_mode_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_db;
  logic             r_db_prev;
  logic             r_rise;
  logic             r_low;
  state_t           r_state;
  logic [3:0]       r_guess_out;
  logic [1:0]       r_guess_mode;
  logic             r_valid;
  logic             r_reject;
  logic             r_busy;
  logic             w_btn_sync;

  assign w_btn_sync = r_rdy_sync[1];

  // Upper bound of the legal guess for each mode.
  function automatic logic in_range(input logic [3:0] g, input logic [1:0] m);
    case (m)
      2'b00:   in_range = (g <= 4'd3);
      2'b01:   in_range = (g <= 4'd7);
      2'b10:   in_range = (g <= 4'd9);
      default: in_range = 1'b1;
    endcase
  endfunction

  // ---- stage: synchronizers, debounce, registered level history ----------
  // btn_db resets high so a press already in progress at reset looks like a
  // held button and must be released before anything is accepted.
  // r_rise / r_low are registered views of the debounced level: a fresh 0->1
  // edge, and "low for two consecutive cycles" (re-arm condition).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdy_sync <= '0;
      r_guess_s1 <= '0;
      r_guess_s2 <= '0;
      r_mode_s1  <= '0;
      r_mode_s2  <= '0;
      r_cnt      <= '0;
      r_btn_db   <= 1'b1;
      r_db_prev  <= 1'b1;
      r_rise     <= 1'b0;
      r_low      <= 1'b0;
    end else begin
      r_rdy_sync <= {r_rdy_sync[0], ready};
      r_guess_s1 <= userGuess;
      r_guess_s2 <= r_guess_s1;
      r_mode_s1  <= gameMode;
      r_mode_s2  <= r_mode_s1;
      r_db_prev  <= r_btn_db;
      r_rise     <= r_btn_db & ~r_db_prev;
      r_low      <= ~r_btn_db & ~r_db_prev;
      if (w_btn_sync == r_btn_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_btn_db <= ~r_btn_db;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---- stage: transaction FSM with registered outputs --------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_WAIT_RELEASE;
      r_guess_out  <= '0;
      r_guess_mode <= '0;
      r_valid      <= 1'b0;
      r_reject     <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_WAIT_RELEASE: begin
          if (r_low) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (r_rise) begin
            r_guess_out  <= r_guess_s2;
            r_guess_mode <= r_mode_s2;
            r_busy       <= 1'b1;
            if (in_range(r_guess_s2, r_mode_s2)) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state  <= S_WAIT_RELEASE;
              r_reject <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Capture registers are untouched here, so the guess stays frozen.
          if (gif.guess_ack) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT_RELEASE;
          end
        end
        default: begin
          r_state <= S_WAIT_RELEASE;
          r_valid <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign gif.guess_out    = r_guess_out;
  assign gif.guess_mode   = r_guess_mode;
  assign gif.guess_valid  = r_valid;
  assign gif.guess_reject = r_reject;
  assign busy             = r_busy;

endmodule

// File: tb/tb_guess_entry.sv
module tb_guess_entry;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;   // edges from press (edge 0) to guess_valid

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] userGuess = '0;
  logic [1:0] gameMode = '0;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  guess_entry_if gif ();

  guess_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .userGuess (userGuess),
    .gameMode  (gameMode),
    .busy      (busy),
    .gif       (gif)
  );

  always #5 clock = ~clock;

  // Reference: largest legal guess per mode.
  function automatic int mode_limit(input logic [1:0] m);
    int lim [4] = '{3, 7, 9, 15};
    return lim[m];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until valid or reject is seen (bounded).
  task automatic watch(output int ticks, output logic saw_v, output logic saw_r);
    ticks = 0; saw_v = 1'b0; saw_r = 1'b0;
    while (ticks < 60 && !saw_v && !saw_r) begin
      tick();
      ticks++;
      saw_v = gif.guess_valid;
      saw_r = gif.guess_reject;
    end
  endtask

  // Release the button and wait (bounded) for IDLE.
  task automatic release_idle(output logic ok);
    int t;
    ready = 1'b0;
    t = 0;
    ok = 1'b0;
    while (t < 40 && !ok) begin
      tick();
      t++;
      ok = (busy == 1'b0);
    end
  endtask

  task automatic press(input logic [3:0] g, input logic [1:0] m);
    userGuess = g;
    gameMode  = m;
    ready     = 1'b1;
  endtask

  task automatic ack_once();
    gif.guess_ack = 1'b1;
    tick();
    gif.guess_ack = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b0;
    gif.guess_ack = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || gif.guess_valid !== 1'b0 || gif.guess_reject !== 1'b0 ||
        gif.guess_out !== 4'd0 || gif.guess_mode !== 2'd0)
      $display("FAIL reset_state: busy=%b valid=%b rej=%b out=%0d mode=%0d want 1 0 0 0 0",
               busy, gif.guess_valid, gif.guess_reject, gif.guess_out, gif.guess_mode);
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      n_checks++;
      if (busy !== ((i < LAT) ? 1'b1 : 1'b0))
        $display("FAIL reset_to_idle edge %0d: busy=%b want %b", i, busy, (i < LAT));
      else n_pass++;
    end
  endtask

  task automatic test_valid_hold();
    int t; logic v, r, ok; int drops;
    press(4'd5, 2'b01);
    watch(t, v, r);
    n_checks++;
    if (t !== LAT + 1 || v !== 1'b1 || r !== 1'b0)
      $display("FAIL valid_latency: ticks=%0d v=%b r=%b want %0d 1 0", t, v, r, LAT + 1);
    else n_pass++;
    n_checks++;
    if (gif.guess_out !== 4'd5 || gif.guess_mode !== 2'b01)
      $display("FAIL valid_capture: out=%0d mode=%0d want 5 1", gif.guess_out, gif.guess_mode);
    else n_pass++;
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gif.guess_valid !== 1'b1) drops++;
    end
    n_checks++;
    if (drops !== 0) $display("FAIL hold_no_ack: drops=%0d want 0", drops);
    else n_pass++;
    ack_once();
    n_checks++;
    if (gif.guess_valid !== 1'b0) $display("FAIL ack_drop: valid=%b want 0", gif.guess_valid);
    else n_pass++;
    release_idle(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL idle_after_ack: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reject();
    int t; logic v, r, ok; int extra;
    press(4'd6, 2'b00);
    watch(t, v, r);
    n_checks++;
    if (t !== LAT + 1 || r !== 1'b1 || v !== 1'b0)
      $display("FAIL reject_latency: ticks=%0d v=%b r=%b want %0d 0 1", t, v, r, LAT + 1);
    else n_pass++;
    tick();
    n_checks++;
    if (gif.guess_reject !== 1'b0) $display("FAIL reject_pulse_width: rej=%b want 0", gif.guess_reject);
    else n_pass++;
    // Short dip then held again: not a release, must be ignored.
    extra = 0;
    ready = 1'b0;
    tick(); tick();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gif.guess_valid || gif.guess_reject) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL reject_no_rearm: events=%0d want 0", extra);
    else n_pass++;
    release_idle(ok);
    press(4'd2, 2'b00);
    watch(t, v, r);
    n_checks++;
    if (v !== 1'b1 || gif.guess_out !== 4'd2)
      $display("FAIL after_reject_valid: v=%b out=%0d want 1 2", v, gif.guess_out);
    else n_pass++;
    ack_once();
    release_idle(ok);
  endtask

  task automatic test_bounce();
    int t; logic v, r, ok; int during, after;
    userGuess = 4'd7;
    gameMode  = 2'b10;
    during = 0;
    for (int i = 0; i < 10; i++) begin
      ready = ~ready;
      tick();
      if (gif.guess_valid || gif.guess_reject) during++;
      tick();
      if (gif.guess_valid || gif.guess_reject) during++;
    end
    ready = 1'b1;
    watch(t, v, r);
    n_checks++;
    if (during !== 0 || t !== LAT + 1 || v !== 1'b1)
      $display("FAIL bounce: during=%0d ticks=%0d v=%b want 0 %0d 1", during, t, v, LAT + 1);
    else n_pass++;
    ack_once();
    after = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gif.guess_valid || gif.guess_reject) after++;
    end
    n_checks++;
    if (after !== 0) $display("FAIL bounce_single: extra=%0d want 0", after);
    else n_pass++;
    release_idle(ok);
  endtask

  task automatic test_freeze();
    int t; logic v, r, ok; int bad;
    press(4'd3, 2'b11);
    watch(t, v, r);
    userGuess = 4'd9;
    gameMode  = 2'b00;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gif.guess_out !== 4'd3 || gif.guess_mode !== 2'b11 || gif.guess_valid !== 1'b1) bad++;
    end
    n_checks++;
    if (v !== 1'b1 || bad !== 0)
      $display("FAIL hold_freeze: v=%b bad=%0d out=%0d want 1 0 3", v, bad, gif.guess_out);
    else n_pass++;
    ack_once();
    release_idle(ok);
  endtask

  task automatic test_reset_held();
    int t; logic v, r, ok; int ev;
    ready = 1'b1;
    userGuess = 4'd1;
    gameMode  = 2'b00;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    ev = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gif.guess_valid || gif.guess_reject || !busy) ev++;
    end
    n_checks++;
    if (ev !== 0) $display("FAIL held_through_reset: events=%0d want 0", ev);
    else n_pass++;
    release_idle(ok);
    press(4'd1, 2'b00);
    watch(t, v, r);
    n_checks++;
    if (!ok || v !== 1'b1 || gif.guess_out !== 4'd1)
      $display("FAIL held_then_press: idle=%b v=%b out=%0d want 1 1 1", ok, v, gif.guess_out);
    else n_pass++;
    ack_once();
    release_idle(ok);
  endtask

  task automatic test_reset_in_hold();
    int t; logic v, r, ok; int ev;
    press(4'd4, 2'b10);
    watch(t, v, r);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (v !== 1'b1 || gif.guess_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL reset_in_hold: v_before=%b valid=%b busy=%b want 1 0 1", v, gif.guess_valid, busy);
    else n_pass++;
    ev = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gif.guess_valid || !busy) ev++;
    end
    n_checks++;
    if (ev !== 0) $display("FAIL reset_in_hold_wait: events=%0d want 0", ev);
    else n_pass++;
    release_idle(ok);
  endtask

  task automatic test_random();
    int t; logic v, r, ok; logic [3:0] g; logic [1:0] m; logic exp_v; int hold;
    for (int n = 0; n < 24; n++) begin
      g = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      exp_v = (int'(g) <= mode_limit(m));
      press(g, m);
      watch(t, v, r);
      n_checks++;
      if (t !== LAT + 1 || v !== exp_v || r !== !exp_v ||
          (exp_v && (gif.guess_out !== g || gif.guess_mode !== m)))
        $display("FAIL random_%0d g=%0d m=%0d: ticks=%0d v=%b r=%b out=%0d want %0d %b %b %0d",
                 n, g, m, t, v, r, gif.guess_out, LAT + 1, exp_v, !exp_v, g);
      else n_pass++;
      if (exp_v) begin
        hold = $urandom_range(0, 5);
        repeat (hold) tick();
        ack_once();
        n_checks++;
        if (gif.guess_valid !== 1'b0) $display("FAIL random_ack_%0d: valid=%b want 0", n, gif.guess_valid);
        else n_pass++;
      end
      // Stray acks while nothing is presented must have no effect.
      gif.guess_ack = 1'($urandom_range(0, 1));
      release_idle(ok);
      gif.guess_ack = 1'b0;
      n_checks++;
      if (ok !== 1'b1 || gif.guess_valid !== 1'b0)
        $display("FAIL random_idle_%0d: idle=%b valid=%b want 1 0", n, ok, gif.guess_valid);
      else n_pass++;
    end
  endtask

  initial begin
    gif.guess_ack = 1'b0;
    test_reset();
    test_valid_hold();
    test_reject();
    test_bounce();
    test_freeze();
    test_reset_held();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
